// File: rtl/tmds_gearbox_pkg.sv
// Shared types, defaults and helpers for the TMDS parallel-to-serial gearbox.
// Contents: FSM state enum, beats() helper, default TMDS clock and idle control words.
package tmds_gearbox_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Pixel clock as seen on the clock lane: five ones then five zeros, LSB first.
  localparam logic [9:0] CLOCK_PATTERN_10B = 10'b0000011111;
  // TMDS control symbol for C1:C0 = 00.
  localparam logic [9:0] IDLE_CTRL_10B     = 10'b1101010100;

  // Number of serial beats needed to emit one symbol.
  function automatic int unsigned beats(input int unsigned word_width,
                                        input int unsigned bits_per_cycle);
    return word_width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/tmds_gearbox_if.sv
// Upstream word handshake into the gearbox.
// Signals: in_valid (source -> gearbox), in_ready (gearbox -> source),
//          in_words (one symbol per data channel).
interface tmds_gearbox_if #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned WORD_WIDTH   = 10
);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] in_words;

  modport master (output in_valid, output in_words, input  in_ready);
  modport slave  (input  in_valid, input  in_words, output in_ready);

endinterface

// File: rtl/tmds_gearbox_fifo.sv
// Synchronous word FIFO with a registered fill level and registered ready flag.
// Ports: clk, reset (sync, active-high), wr_en/wr_data (write side, gated by ready),
//        rd_en/rd_data_c (show-ahead read of the head entry), level, ready.
module tmds_word_fifo #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tmds_word_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_d;
  logic              do_wr;
  logic              do_rd;

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign do_wr     = wr_en && ready;
  assign do_rd     = rd_en && (level != '0);
  assign rd_data_c = mem[rd_ptr];

  // Next fill level; push and pop together leave it unchanged.
  always_comb begin
    level_d = level;
    if (do_wr && !do_rd) begin
      level_d = level + LVL_W'(1);
    end else if (!do_wr && do_rd) begin
      level_d = level - LVL_W'(1);
    end
  end

  // Pointers, level and ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      ready <= (level_d < LVL_W'(DEPTH));
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tmds_gearbox.sv
// Parallel-to-serial TMDS gearbox: buffers NUM_CHANNELS-wide symbols and emits
// BITS_PER_CYCLE bits per channel per clock, plus a generated clock lane.
// Ports: clk_pixel_x5, reset (sync, active-high), in_bus (valid/ready/words),
//        out_bits (index NUM_CHANNELS = clock lane, bit 0 sent first), out_valid,
//        word_start, underflow (sticky), clear_underflow, fifo_level.
module tmds_gearbox
  import tmds_gearbox_pkg::*;
#(
  parameter int unsigned           NUM_CHANNELS   = 3,
  parameter int unsigned           WORD_WIDTH     = 10,
  parameter int unsigned           BITS_PER_CYCLE = 2,
  parameter int unsigned           FIFO_DEPTH     = 4,
  parameter bit                    LSB_FIRST      = 1'b1,
  parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN  = WORD_WIDTH'(CLOCK_PATTERN_10B),
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD      = WORD_WIDTH'(IDLE_CTRL_10B)
) (
  input  logic                                      clk_pixel_x5,
  input  logic                                      reset,
  tmds_gearbox_if.slave                             in_bus,
  output logic [NUM_CHANNELS:0][BITS_PER_CYCLE-1:0] out_bits,
  output logic                                      out_valid,
  output logic                                      word_start,
  output logic                                      underflow,
  input  logic                                      clear_underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]           fifo_level
);

  localparam int unsigned BEATS  = beats(WORD_WIDTH, BITS_PER_CYCLE);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DATA_W = NUM_CHANNELS * WORD_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if ((WORD_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("tmds_gearbox: WORD_WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  state_t                               state_q;
  state_t                               state_d;
  logic [BEAT_W-1:0]                    beat_q;
  logic [NUM_CHANNELS:0][WORD_WIDTH-1:0] shift_q;
  logic [DATA_W-1:0]                    fifo_head;
  logic                                 fifo_ready;
  logic                                 fifo_wr;
  logic                                 load_c;
  logic                                 pop_c;
  logic                                 load_idle_c;

  assign fifo_wr         = in_bus.in_valid && fifo_ready;
  assign in_bus.in_ready = fifo_ready;

  tmds_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_pixel_x5),
    .reset     (reset),
    .wr_en     (fifo_wr),
    .wr_data   (in_bus.in_words),
    .rd_en     (pop_c),
    .rd_data_c (fifo_head),
    .level     (fifo_level),
    .ready     (fifo_ready)
  );

  // State register.
  always_ff @(posedge clk_pixel_x5) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: RUN is only left through reset so the clock lane never stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_level != '0) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Symbol load control; an empty FIFO at the last beat substitutes the idle word.
  always_comb begin
    load_c      = 1'b0;
    pop_c       = 1'b0;
    load_idle_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_level != '0) begin
          load_c = 1'b1;
          pop_c  = 1'b1;
        end
      end
      RUN: begin
        if (beat_q == LAST_BEAT) begin
          load_c = 1'b1;
          if (fifo_level != '0) pop_c       = 1'b1;
          else                  load_idle_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shifters, beat counter, status flags.
  always_ff @(posedge clk_pixel_x5) begin
    if (reset) begin
      beat_q     <= '0;
      shift_q    <= '0;
      out_valid  <= 1'b0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (load_c) begin
        beat_q                <= '0;
        shift_q[NUM_CHANNELS] <= CLOCK_PATTERN;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
          shift_q[c] <= load_idle_c ? IDLE_WORD : fifo_head[c*WORD_WIDTH +: WORD_WIDTH];
        end
      end else if (state_q == RUN) begin
        beat_q <= beat_q + BEAT_W'(1);
        for (int unsigned c = 0; c <= NUM_CHANNELS; c++) begin
          shift_q[c] <= LSB_FIRST ? (shift_q[c] >> BITS_PER_CYCLE)
                                  : (shift_q[c] << BITS_PER_CYCLE);
        end
      end
      out_valid  <= (state_d == RUN);
      word_start <= load_c;
      // Set has priority over clear.
      if (load_idle_c)          underflow <= 1'b1;
      else if (clear_underflow) underflow <= 1'b0;
    end
  end

  // Serial taps come straight off the shifter ends; zero while IDLE.
  always_comb begin
    out_bits = '0;
    for (int unsigned c = 0; c <= NUM_CHANNELS; c++) begin
      for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
        out_bits[c][j] = LSB_FIRST ? shift_q[c][j] : shift_q[c][WORD_WIDTH-1-j];
      end
    end
  end

endmodule

// File: tb/tb_tmds_gearbox.sv
// Testbench for tmds_gearbox: DUT A uses defaults (LSB first, 2 bits/beat),
// DUT B uses MSB first at 1 bit/beat. Monitors rebuild symbols into queues
// that are matched against the expected-symbol scoreboard.
module tb_tmds_gearbox;

  typedef logic [3:0][9:0] sym_t;

  localparam logic [9:0] CLK_PAT = 10'b0000011111;
  localparam logic [9:0] IDLE_W  = 10'h354;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, rst_b;
  logic [3:0][1:0]  out_bits_a;
  logic [3:0][0:0]  out_bits_b;
  logic             out_valid_a, out_valid_b;
  logic             word_start_a, word_start_b;
  logic             underflow_a, underflow_b;
  logic             clear_a, clear_b;
  logic [2:0]       level_a, level_b;

  tmds_gearbox_if #(.NUM_CHANNELS(3), .WORD_WIDTH(10)) bus_a ();
  tmds_gearbox_if #(.NUM_CHANNELS(3), .WORD_WIDTH(10)) bus_b ();

  tmds_gearbox dut_a (
    .clk_pixel_x5    (clk),
    .reset           (rst_a),
    .in_bus          (bus_a),
    .out_bits        (out_bits_a),
    .out_valid       (out_valid_a),
    .word_start      (word_start_a),
    .underflow       (underflow_a),
    .clear_underflow (clear_a),
    .fifo_level      (level_a)
  );

  tmds_gearbox #(.BITS_PER_CYCLE(1), .LSB_FIRST(1'b0)) dut_b (
    .clk_pixel_x5    (clk),
    .reset           (rst_b),
    .in_bus          (bus_b),
    .out_bits        (out_bits_b),
    .out_valid       (out_valid_b),
    .word_start      (word_start_b),
    .underflow       (underflow_b),
    .clear_underflow (clear_b),
    .fifo_level      (level_b)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  sym_t exp_a[$], got_a[$], exp_b[$], got_b[$];
  int   gap_err_a = 0;
  int   per_b     = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Rebuild DUT A symbols (LSB first, 2 bits/beat) and check the word_start cadence.
  initial begin : mon_a
    sym_t acc;
    int   beat    = -1;
    int   last_ws = -1;
    acc = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        beat    = -1;
        last_ws = -1;
      end else if (out_valid_a) begin
        if (word_start_a) begin
          if (last_ws >= 0 && (cyc - last_ws) != 5) gap_err_a++;
          last_ws = cyc;
          beat    = 0;
        end
        if (beat >= 0) begin
          for (int c = 0; c < 4; c++)
            for (int j = 0; j < 2; j++) acc[c][beat*2+j] = out_bits_a[c][j];
          if (beat == 4) begin
            got_a.push_back(acc);
            beat = -1;
          end else begin
            beat++;
          end
        end
      end else if (last_ws >= 0) begin
        gap_err_a++;
      end
    end
  end

  // Rebuild DUT B symbols (MSB first, 1 bit/beat) and record the word_start period.
  initial begin : mon_b
    sym_t acc;
    int   beat    = -1;
    int   last_ws = -1;
    acc = '0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        beat    = -1;
        last_ws = -1;
      end else if (out_valid_b) begin
        if (word_start_b) begin
          if (last_ws >= 0) per_b = cyc - last_ws;
          last_ws = cyc;
          beat    = 0;
        end
        if (beat >= 0) begin
          for (int c = 0; c < 4; c++) acc[c][9-beat] = out_bits_b[c][0];
          if (beat == 9) begin
            got_b.push_back(acc);
            beat = -1;
          end else begin
            beat++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sym_t mk_sym(input logic [9:0] w0, input logic [9:0] w1,
                                  input logic [9:0] w2);
    return {CLK_PAT, w2, w1, w0};
  endfunction

  task automatic drive_a(input sym_t s);
    bus_a.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) bus_a.in_words[c] = s[c];
  endtask

  task automatic drive_b(input sym_t s);
    bus_b.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) bus_b.in_words[c] = s[c];
  endtask

  task automatic reset_a();
    bus_a.in_valid = 1'b0;
    clear_a        = 1'b0;
    rst_a          = 1'b1;
    repeat (2) tick();
    rst_a = 1'b0;
    exp_a.delete();
    got_a.delete();
    gap_err_a = 0;
  endtask

  task automatic cmp_sym(input string tag, input sym_t got, input sym_t exp);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_ch%0d", tag, c), 64'(got[c]), 64'(exp[c]));
  endtask

  // Wait (bounded) until DUT A has produced every expected symbol, then match in order.
  task automatic check_a(input string tag);
    int n = exp_a.size();
    int k = 0;
    while (got_a.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_symcount"}, 64'(got_a.size() >= n), 64'(1));
    for (int i = 0; i < n && got_a.size() > 0; i++)
      cmp_sym($sformatf("%s_sym%0d", tag, i), got_a.pop_front(), exp_a.pop_front());
  endtask

  task automatic check_b(input string tag);
    int n = exp_b.size();
    int k = 0;
    while (got_b.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_symcount"}, 64'(got_b.size() >= n), 64'(1));
    for (int i = 0; i < n && got_b.size() > 0; i++)
      cmp_sym($sformatf("%s_sym%0d", tag, i), got_b.pop_front(), exp_b.pop_front());
  endtask

  task automatic wait_ws_a(input string tag);
    int k = 0;
    @(negedge clk);
    while (word_start_a !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ws_seen"}, 64'(word_start_a), 64'(1));
  endtask

  initial begin : stim
    sym_t s;
    int   k;
    logic saw_full;

    bus_a.in_valid = 1'b0;
    bus_a.in_words = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_words = '0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    rst_b   = 1'b1;

    // Reset state.
    reset_a();
    @(negedge clk);
    chk("rst_out_bits",   64'(out_bits_a),     64'(0));
    chk("rst_out_valid",  64'(out_valid_a),    64'(0));
    chk("rst_word_start", 64'(word_start_a),   64'(0));
    chk("rst_underflow",  64'(underflow_a),    64'(0));
    chk("rst_level",      64'(level_a),        64'(0));
    chk("rst_in_ready",   64'(bus_a.in_ready), 64'(1));

    // First word: latency and beat-0 content.
    tick();
    s = mk_sym(10'h3FF, 10'h000, 10'h155);
    drive_a(s);
    exp_a.push_back(s);
    tick();
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_level_t1",  64'(level_a),      64'(1));
    chk("lat_ws_t1",     64'(word_start_a), 64'(0));
    tick();
    @(negedge clk);
    chk("lat_ws_t2",     64'(word_start_a),  64'(1));
    chk("lat_valid_t2",  64'(out_valid_a),   64'(1));
    chk("beat0_ch0",     64'(out_bits_a[0]), 64'(2'b11));
    chk("beat0_ch1",     64'(out_bits_a[1]), 64'(2'b00));
    chk("beat0_ch2",     64'(out_bits_a[2]), 64'(2'b01));
    chk("beat0_clk",     64'(out_bits_a[3]), 64'(2'b11));
    check_a("basic");

    // Continuous input: FIFO fills, stream stays gap-free, no underflow.
    reset_a();
    tick();
    k        = 1;
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s = mk_sym(10'(k), 10'(k + 64), 10'(k + 128));
      drive_a(s);
      @(negedge clk);
      chk("ready_vs_level", 64'(bus_a.in_ready), 64'(level_a < 3'd4));
      if (level_a == 3'd4) saw_full = 1'b1;
      if (bus_a.in_ready) begin
        exp_a.push_back(s);
        k++;
      end
      tick();
    end
    bus_a.in_valid = 1'b0;
    chk("cont_saw_full",  64'(saw_full),    64'(1));
    chk("cont_underflow", 64'(underflow_a), 64'(0));
    check_a("cont");
    chk("cont_gap_free",  64'(gap_err_a),   64'(0));

    // Underflow: two words then the idle control symbol; sticky flag and clear.
    reset_a();
    tick();
    s = mk_sym(10'h0AB, 10'h1CD, 10'h2EF);
    drive_a(s);
    exp_a.push_back(s);
    tick();
    s = mk_sym(10'h311, 10'h022, 10'h133);
    drive_a(s);
    exp_a.push_back(s);
    tick();
    bus_a.in_valid = 1'b0;
    exp_a.push_back(mk_sym(IDLE_W, IDLE_W, IDLE_W));
    check_a("uflow");
    chk("uflow_set", 64'(underflow_a), 64'(1));
    wait_ws_a("uflow_sync");
    tick();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    @(negedge clk);
    chk("uflow_cleared", 64'(underflow_a), 64'(0));
    tick();
    clear_a = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("uflow_set_wins", 64'(underflow_a), 64'(1));
    tick();
    clear_a = 1'b0;

    // Push and pop in the same cycle at level 2.
    reset_a();
    tick();
    s = mk_sym(10'h101, 10'h102, 10'h103);
    drive_a(s);
    exp_a.push_back(s);
    tick();
    s = mk_sym(10'h201, 10'h202, 10'h203);
    drive_a(s);
    exp_a.push_back(s);
    tick();
    s = mk_sym(10'h301, 10'h302, 10'h303);
    drive_a(s);
    exp_a.push_back(s);
    @(negedge clk);
    chk("pp_ws_c2",    64'(word_start_a), 64'(1));
    chk("pp_level_c2", 64'(level_a),      64'(1));
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    tick();
    tick();
    s = mk_sym(10'h011, 10'h022, 10'h044);
    drive_a(s);
    exp_a.push_back(s);
    @(negedge clk);
    chk("pp_level_before", 64'(level_a),        64'(2));
    chk("pp_ready_before", 64'(bus_a.in_ready), 64'(1));
    tick();
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("pp_level_after",  64'(level_a),      64'(2));
    chk("pp_ws_after",     64'(word_start_a), 64'(1));
    check_a("pushpop");

    // Reset at beat 2 with three words buffered and underflow set.
    wait_ws_a("mid_sync");
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_a(mk_sym(10'(i + 5), 10'(i + 6), 10'(i + 7)));
    end
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    tick();
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_level_pre",     64'(level_a),     64'(3));
    chk("mid_underflow_pre", 64'(underflow_a), 64'(1));
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_out_bits",  64'(out_bits_a),     64'(0));
    chk("mid_out_valid", 64'(out_valid_a),    64'(0));
    chk("mid_level",     64'(level_a),        64'(0));
    chk("mid_in_ready",  64'(bus_a.in_ready), 64'(1));
    chk("mid_underflow", 64'(underflow_a),    64'(0));
    repeat (3) tick();
    @(negedge clk);
    chk("mid_stays_idle", 64'(out_valid_a), 64'(0));
    exp_a.delete();
    got_a.delete();

    // DUT B: MSB first, one bit per beat.
    tick();
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_level", 64'(level_b),        64'(0));
    chk("b_rst_ready", 64'(bus_b.in_ready), 64'(1));
    tick();
    s = mk_sym(10'h200, 10'h001, 10'h2AA);
    drive_b(s);
    exp_b.push_back(s);
    tick();
    s = mk_sym(10'h0F0, 10'h3FF, 10'h155);
    drive_b(s);
    exp_b.push_back(s);
    tick();
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    chk("b_first_ws",  64'(word_start_b),  64'(1));
    chk("b_first_bit", 64'(out_bits_b[0]), 64'(1));
    chk("b_first_clk", 64'(out_bits_b[3]), 64'(0));
    check_b("msb");
    chk("b_ws_period", 64'(per_b), 64'(10));
    repeat (12) tick();
    @(negedge clk);
    chk("b_underflow", 64'(underflow_b), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_gearbox.md
# tmds_gearbox

Parametrised, single-clock parallel-to-serial gearbox for the HDMI/TMDS output path. It accepts NUM_CHANNELS encoded words per transfer through a valid/ready handshake and buffers them in a small FIFO. Each word is emitted as BITS_PER_CYCLE bits per channel per clock, with a generated pixel-clock channel alongside. It sits between the TMDS encoders and the vendor DDR/SDR output primitives, replacing fixed 10:1 primitive serialisers on targets that lack them. It adds underflow detection and idle-word substitution.

## Interface
- NUM_CHANNELS, 3: data channels; the clock channel is extra.
- WORD_WIDTH, 10: bits per symbol.
- BITS_PER_CYCLE, 2: bits emitted per channel per clock; must divide WORD_WIDTH (1 = SDR, 2 = DDR pair).
- FIFO_DEPTH, 4: word buffer depth; power of two, ≥2.
- LSB_FIRST, 1: 1 = word bit 0 emitted first; 0 = bit WORD_WIDTH-1 first.
- CLOCK_PATTERN, 10'b0000011111: WORD_WIDTH-bit word sent on the clock channel every symbol.
- IDLE_WORD, 10'b1101010100: word substituted on every data channel during underflow.
- clk_pixel_x5  in  1  serial clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_words valid.
- in_ready  out  1  FIFO can accept a word.
- in_words  in  [NUM_CHANNELS-1:0][WORD_WIDTH-1:0]  one symbol per channel.
- out_bits  out  [NUM_CHANNELS:0][BITS_PER_CYCLE-1:0]  emitted bits; index NUM_CHANNELS is the clock channel; bit 0 is sent first.
- out_valid  out  1  out_bits carry symbol data (RUN state).
- word_start  out  1  out_bits holds beat 0 of a symbol.
- underflow  out  1  sticky; set when an idle word was substituted.
- clear_underflow  in  1  clears underflow.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words buffered.

## Operation
- BEATS = WORD_WIDTH/BITS_PER_CYCLE.
- Beat counter runs 0..BEATS-1 and wraps to 0.
- FIFO write when in_valid && in_ready.
- in_ready = (fifo_level < FIFO_DEPTH), computed from the registered level. No write is accepted while full, even if a read occurs in the same cycle.
- State IDLE (reset state):
  - out_bits = 0, out_valid = 0, word_start = 0.
  - Leaves IDLE when fifo_level ≠ 0: pops a word, loads the shifters plus CLOCK_PATTERN, beat = 0, goes to RUN.
- State RUN:
  - Each cycle the shifters advance by BITS_PER_CYCLE.
  - At beat BEATS-1 the next symbol is loaded:
    - FIFO non-empty: pop it.
    - FIFO empty: load IDLE_WORD on all data channels and CLOCK_PATTERN on the clock channel, and set underflow. A write arriving in the same cycle is not bypassed.
  - RUN never returns to IDLE except on reset, so the output clock is never interrupted.
- Bit order: beat k, bit j emits word[k·BITS_PER_CYCLE+j] if LSB_FIRST, otherwise word[WORD_WIDTH-1-(k·BITS_PER_CYCLE+j)].
- Clock channel follows the same order rule.
- underflow: set/clear in the same cycle → set wins.
- reset: FIFO flushed, fifo_level = 0, in_ready = 1 from the cycle after reset, all outputs 0, state IDLE, underflow = 0. Mid-symbol reset truncates the symbol immediately.

## Timing
- All outputs are registered.
- Word accepted in cycle t (empty FIFO, IDLE): fifo_level = 1 at t+1; beat 0 on out_bits with word_start = 1 and out_valid = 1 at t+2.
- In RUN, a word popped at beat BEATS-1 appears at beat 0 on the next cycle, so symbols are emitted back-to-back with no gap.
- Sustained throughput: 1 word per BEATS cycles. Upstream must average no faster than that.
- fifo_level updates one cycle after a push or pop; simultaneous push and pop leave it unchanged.

## Structure
- Package tmds_gearbox_pkg:
  - state enum {IDLE, RUN};
  - function beats(word_width, bits_per_cycle);
  - default TMDS constants CLOCK_PATTERN_10B and IDLE_CTRL_10B.
- Sub-module tmds_word_fifo: synchronous FIFO, data width NUM_CHANNELS·WORD_WIDTH, depth FIFO_DEPTH, registered count.
- Top level holds the state machine, beat counter, NUM_CHANNELS+1 shift registers and the underflow flag.
- Elaboration assertion: WORD_WIDTH % BITS_PER_CYCLE == 0.

## Test plan
- Defaults; write words {0x3FF, 0x000, 0x155} in cycle 0 → cycle 2: word_start = 1, out_bits ch0 = 2'b11, ch1 = 2'b00, ch2 = 2'b01, clock ch = 2'b11. After 5 cycles all 10 bits of each word are reproduced LSB-first.
- Continuous in_valid pushing 0x001, 0x002, … → in_ready low once fifo_level = 4; the serial stream is gap-free; word_start every 5th cycle; no underflow.
- Stop input after 2 words → the third symbol is 0x354 on all data channels, underflow = 1 and stays set; clear_underflow → 0 on the next cycle.
- LSB_FIRST = 0, BITS_PER_CYCLE = 1, word 0x200 → first out_bit = 1, then nine 0s; word_start period = 10.
- Assert reset at beat 2 of a symbol with 3 words buffered → next cycle: out_bits = 0, out_valid = 0, fifo_level = 0, in_ready = 1, underflow = 0.
- Push and pop in the same cycle at fifo_level = 2 → fifo_level remains 2.
